// File: rtl/xsim_msg_pkg.sv
// Shared header-field layout and arbiter state type for the xsim message channel.
package xsim_msg_pkg;

    localparam int MSG_LEN_LSB = 0;
    localparam int MSG_LEN_W   = 16;
    // The id field sits above the length and is passed through untouched.
    localparam int MSG_ID_LSB  = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping past N-1.
module rr_pick
    import xsim_msg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW:0] pos;

    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!any && req[pos[IW-1:0]]) begin
                any = 1'b1;
                idx = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/xsim_msg_arbiter.sv
// Round-robin, message-atomic arbiter merging NUM_REQ portal message streams
// onto the single msgSource beat channel.
module xsim_msg_arbiter
    import xsim_msg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BEAT_W  = 32,
    parameter int LEN_W   = MSG_LEN_W
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NUM_REQ-1:0]          req_src_rdy,
    output logic [NUM_REQ-1:0]          req_dst_rdy,
    input  logic [NUM_REQ*BEAT_W-1:0]   req_beat,
    output logic                        msg_src_rdy,
    input  logic                        msg_dst_rdy,
    output logic [BEAT_W-1:0]           msg_beat,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             first_q, first_d;

    logic             pick_any;
    logic [IDW-1:0]   pick_idx;
    logic [BEAT_W-1:0] beats [NUM_REQ];
    logic [BEAT_W-1:0] sel_beat;
    logic [LEN_W-1:0] hdr_len;
    logic             fire;
    logic             last_beat;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (req_src_rdy),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign beats[gi]       = req_beat[gi*BEAT_W +: BEAT_W];
            assign req_dst_rdy[gi] = (state_q == ARB_XFER) && (grant_q == IDW'(gi)) && msg_dst_rdy;
        end
    endgenerate

    // Zero-latency pass-through of the granted source while a message is in flight.
    assign sel_beat    = beats[grant_q];
    assign busy        = (state_q == ARB_XFER);
    assign msg_src_rdy = busy && req_src_rdy[grant_q];
    assign msg_beat    = busy ? sel_beat : '0;
    assign grant_id    = grant_q;
    assign fire        = msg_src_rdy && msg_dst_rdy;
    assign hdr_len     = sel_beat[MSG_LEN_LSB +: LEN_W];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        last_beat   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    first_d = 1'b1;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (fire) begin
                    // A length of 0 or 1 in the header means a header-only message.
                    if (first_q) begin
                        first_d   = 1'b0;
                        last_beat = (hdr_len <= LEN_W'(1));
                        remaining_d = last_beat ? '0 : hdr_len - LEN_W'(1);
                    end else begin
                        last_beat   = (remaining_q <= LEN_W'(1));
                        remaining_d = last_beat ? '0 : remaining_q - LEN_W'(1);
                    end
                    if (last_beat) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + IDW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
        end
    end

endmodule
